// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared defaults, level type and vector-address helper for the
//                nested interrupt sequencer (irq_nest_ctrl, pc_save_stack).
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int          NUM_IRQ_DEF    = 3;
    localparam int          ADDR_W_DEF     = 32;
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_3038;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0038;

    // Level encoding: 0 = user code, k+1 = handler k running.
    localparam int LEVEL_W = $clog2(NUM_IRQ_DEF + 1);
    typedef logic [LEVEL_W-1:0] level_t;

    // Vector address of line idx: base + idx * stride.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] idx);
        return base + stride * idx;
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/pc_save_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pc_save_stack
//  Description : LIFO holding the PCs of preempted contexts.
//                Ports: clk, rst_n (async, active-low), push/push_data write
//                the entry at sp and increment sp; pop decrements sp;
//                top_data is the entry at sp-1 (combinational).
//                The caller never pushes when full nor pops when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_save_stack #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_m1;

    assign sp_m1    = sp - 1'b1;
    assign top_data = (sp == '0) ? '0 : mem[sp_m1[IDX_W-1:0]];

    // Pointer is the only state that needs reset; contents are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (pop) begin
            sp <= sp_m1;
        end else if (push) begin
            sp <= sp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

endmodule : pc_save_stack
`default_nettype wire

// File: rtl/irq_nest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_nest_ctrl
//  Description : Nested interrupt sequencer between PC-select and fetch.
//                Highest irq_req index wins; accepted interrupts push pc_seq
//                and redirect to their vector, irq_done pops and resumes.
//                Ports: clk, rst_n, irq_req, irq_en, irq_done, pc_seq in;
//                pc_next (comb), irq_active, cur_level, take_pulse,
//                ret_pulse, stk_err out.
//                Optional macro IRQ_LATCH_EN: rising edges on irq_req are
//                captured in a pending register used for take evaluation.
//                Vector arithmetic is 32-bit, truncated/extended to ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_nest_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ    = NUM_IRQ_DEF,
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_IRQ-1:0]             irq_req,
    input  logic                           irq_en,
    input  logic                           irq_done,
    input  logic [ADDR_W-1:0]              pc_seq,
    output logic [ADDR_W-1:0]              pc_next,
    output logic [NUM_IRQ-1:0]             irq_active,
    output logic [$clog2(NUM_IRQ+1)-1:0]   cur_level,
    output logic                           take_pulse,
    output logic                           ret_pulse,
    output logic                           stk_err
);

    localparam int LVL_W = $clog2(NUM_IRQ + 1);

    logic [NUM_IRQ-1:0] req_src;
    logic [NUM_IRQ-1:0] req_eval;
    logic               p_found;
    logic [LVL_W-1:0]   p_idx;
    logic [LVL_W-1:0]   p_lvl;
    logic               take;
    logic               ret;
    logic [LVL_W-1:0]   clr_idx;
    logic [NUM_IRQ-1:0] active_after;
    logic [LVL_W-1:0]   lvl_after;
    logic [ADDR_W-1:0]  vec_pc;
    logic [ADDR_W-1:0]  stack_top;

`ifdef IRQ_LATCH_EN
    logic [NUM_IRQ-1:0] req_d;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] take_mask;

    always_comb begin
        take_mask = '0;
        if (take) begin
            take_mask[p_idx] = 1'b1;
        end
    end

    // An edge on a live line is held here until its handler returns,
    // because the level check keeps it from being taken before then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d   <= '0;
            pending <= '0;
        end else begin
            req_d   <= irq_req;
            pending <= (pending | (irq_req & ~req_d)) & ~take_mask;
        end
    end

    assign req_src = pending;
`else
    assign req_src = irq_req;
`endif

    assign req_eval = irq_en ? req_src : '0;

    // Highest set index wins: later iterations overwrite earlier ones.
    always_comb begin
        p_found = 1'b0;
        p_idx   = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (req_eval[k]) begin
                p_found = 1'b1;
                p_idx   = LVL_W'(k);
            end
        end
    end

    assign p_lvl = p_idx + 1'b1;

    // rst_n gating keeps the pulses low and pc_next = pc_seq while in reset.
    assign ret  = rst_n && irq_done && (cur_level != '0);
    assign take = rst_n && !ret && p_found && (p_lvl > cur_level);

    // Level after a return: highest handler still live, or user level.
    assign clr_idx = cur_level - 1'b1;
    always_comb begin
        active_after          = irq_active;
        active_after[clr_idx] = 1'b0;
        lvl_after             = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (active_after[k]) begin
                lvl_after = LVL_W'(k + 1);
            end
        end
    end

    assign vec_pc = ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(p_idx)));

    always_comb begin
        if (ret) begin
            pc_next = stack_top;
        end else if (take) begin
            pc_next = vec_pc;
        end else begin
            pc_next = pc_seq;
        end
    end

    assign take_pulse = take;
    assign ret_pulse  = ret;

    pc_save_stack #(
        .DEPTH  (NUM_IRQ),
        .ADDR_W (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (take),
        .pop       (ret),
        .push_data (pc_seq),
        .top_data  (stack_top)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_active <= '0;
            cur_level  <= '0;
            stk_err    <= 1'b0;
        end else begin
            if (ret) begin
                irq_active <= active_after;
                cur_level  <= lvl_after;
            end else if (take) begin
                irq_active[p_idx] <= 1'b1;
                cur_level         <= p_lvl;
            end
            if (irq_done && (cur_level == '0)) begin
                stk_err <= 1'b1;
            end
        end
    end

endmodule : irq_nest_ctrl
`default_nettype wire
